// File: rtl/clk_switch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_switch_pkg
// Description : Shared types and constants for the clock-switch sequencer.
// Revision    : 1.0  initial release
// ============================================================================
package clk_switch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_OK = 2'd1,
        ST_SETTLE  = 2'd2,
        ST_REVERT  = 2'd3
    } clk_sw_state_e;

    // Terminal count of the shared down-counter.
    localparam int unsigned C_TMR_ZERO = 0;

endpackage : clk_switch_pkg
`default_nettype wire

// File: rtl/clk_switch_if.sv
`default_nettype none
// ============================================================================
// Module      : clk_switch_if
// Description : Switch-request valid/ready handshake between the clock
//               manager (master) and the switch sequencer (slave).
// Revision    : 1.0  initial release
// ============================================================================
interface clk_switch_if;

    logic req_valid_i;
    logic req_sel_i;
    logic req_ready_o;

    modport master (
        output req_valid_i,
        output req_sel_i,
        input  req_ready_o
    );

    modport slave (
        input  req_valid_i,
        input  req_sel_i,
        output req_ready_o
    );

endinterface : clk_switch_if
`default_nettype wire

// File: rtl/clk_sw_timer.sv
`default_nettype none
// ============================================================================
// Module      : clk_sw_timer
// Description : Loadable down-counter; expired while the count sits at zero.
// Revision    : 1.0  initial release
// ============================================================================
module clk_sw_timer
    import clk_switch_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_load,
    input  wire logic [CNT_W-1:0] i_load_val,
    output logic                  o_expired
);

    localparam logic [CNT_W-1:0] C_ZERO = CNT_W'(C_TMR_ZERO);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= C_ZERO;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != C_ZERO) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expired = (r_cnt == C_ZERO);

endmodule : clk_sw_timer
`default_nettype wire

// File: rtl/clk_switch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clk_switch_ctrl
// Description : Glitch-free clock-mux sequencer: request handshake, select
//               hold-off until settled, revert on loss, automatic failover.
// Revision    : 1.0  initial release
// ============================================================================
module clk_switch_ctrl
    import clk_switch_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter bit          AUTO_FAILOVER  = 1'b1,
    parameter int unsigned CNT_W          = 16
) (
    input  wire logic   clk_i,
    input  wire logic   rst_i,
    clk_switch_if.slave req_if,
    input  wire logic   clk0_ok_i,
    input  wire logic   clk1_ok_i,
    output logic        select_o,
    output logic        cur_sel_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        failover_o
);

    generate
        if (SETTLE_CYCLES < 1 || TIMEOUT_CYCLES < 1 ||
            ((SETTLE_CYCLES - 1) >> CNT_W) != 0 ||
            ((TIMEOUT_CYCLES - 1) >> CNT_W) != 0) begin : g_bad_params
            $error("clk_switch_ctrl: illegal SETTLE_CYCLES/TIMEOUT_CYCLES/CNT_W");
        end
    endgenerate

    // Timer is loaded with N-1 so that a state lasts exactly N cycles.
    localparam logic [CNT_W-1:0] C_SETTLE_LD  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_TIMEOUT_LD = CNT_W'(TIMEOUT_CYCLES - 1);

    clk_sw_state_e    r_state, w_state_nxt;
    logic             r_select, w_select_nxt;
    logic             r_cur, w_cur_nxt;
    logic             r_target, w_target_nxt;
    logic             r_prev, w_prev_nxt;
    logic             r_fo, w_fo_nxt;
    logic             r_done, w_done_nxt;
    logic             r_err, w_err_nxt;
    logic             r_fo_pulse, w_fo_pulse_nxt;
    logic             w_tmr_load;
    logic [CNT_W-1:0] w_tmr_val;
    logic             w_tmr_expired;
    logic             w_ready;
    logic             w_accept;
    logic             w_target_ok;
    logic             w_active_ok;
    logic             w_other_ok;

    clk_sw_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk_i),
        .rst        (rst_i),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_expired  (w_tmr_expired)
    );

    assign w_ready     = !rst_i && (r_state == ST_IDLE);
    assign w_accept    = req_if.req_valid_i && w_ready;
    assign w_target_ok = r_target ? clk1_ok_i : clk0_ok_i;
    assign w_active_ok = r_cur ? clk1_ok_i : clk0_ok_i;
    assign w_other_ok  = r_cur ? clk0_ok_i : clk1_ok_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_select   <= 1'b0;
            r_cur      <= 1'b0;
            r_target   <= 1'b0;
            r_prev     <= 1'b0;
            r_fo       <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_fo_pulse <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_select   <= w_select_nxt;
            r_cur      <= w_cur_nxt;
            r_target   <= w_target_nxt;
            r_prev     <= w_prev_nxt;
            r_fo       <= w_fo_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_fo_pulse <= w_fo_pulse_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_select_nxt   = r_select;
        w_cur_nxt      = r_cur;
        w_target_nxt   = r_target;
        w_prev_nxt     = r_prev;
        w_fo_nxt       = r_fo;
        w_done_nxt     = 1'b0;
        w_err_nxt      = 1'b0;
        w_fo_pulse_nxt = 1'b0;
        w_tmr_load     = 1'b0;
        w_tmr_val      = C_TIMEOUT_LD;

        unique case (r_state)
            ST_IDLE: begin
                // An accepted request always wins over failover.
                if (w_accept) begin
                    w_target_nxt = req_if.req_sel_i;
                    w_prev_nxt   = r_select;
                    w_fo_nxt     = 1'b0;
                    if (req_if.req_sel_i == r_cur) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT_OK;
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = C_TIMEOUT_LD;
                    end
                end else if (AUTO_FAILOVER && !w_active_ok && w_other_ok) begin
                    w_target_nxt = !r_cur;
                    w_prev_nxt   = r_select;
                    w_fo_nxt     = 1'b1;
                    w_state_nxt  = ST_WAIT_OK;
                    w_tmr_load   = 1'b1;
                    w_tmr_val    = C_TIMEOUT_LD;
                end
            end
            ST_WAIT_OK: begin
                if (w_target_ok) begin
                    w_select_nxt = r_target;
                    w_state_nxt  = ST_SETTLE;
                    w_tmr_load   = 1'b1;
                    w_tmr_val    = C_SETTLE_LD;
                end else if (w_tmr_expired) begin
                    w_err_nxt   = 1'b1;
                    w_fo_nxt    = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (w_tmr_expired) begin
                    w_cur_nxt      = r_select;
                    w_done_nxt     = 1'b1;
                    w_fo_pulse_nxt = r_fo;
                    w_fo_nxt       = 1'b0;
                    w_state_nxt    = ST_IDLE;
                end else if (!w_target_ok) begin
                    w_select_nxt = r_prev;
                    w_state_nxt  = ST_REVERT;
                    w_tmr_load   = 1'b1;
                    w_tmr_val    = C_SETTLE_LD;
                end
            end
            ST_REVERT: begin
                if (w_tmr_expired) begin
                    w_err_nxt   = 1'b1;
                    w_fo_nxt    = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign req_if.req_ready_o = w_ready;
    assign select_o           = r_select;
    assign cur_sel_o          = r_cur;
    assign busy_o             = (r_state != ST_IDLE);
    assign done_o             = r_done;
    assign err_o              = r_err;
    assign failover_o         = r_fo_pulse;

endmodule : clk_switch_ctrl
`default_nettype wire
